seg_scan_capture: RTL

SEG_SCAN_CAPTURE -- requirements
Module: seg_scan_capture

---
 rtl/seg_scan_pkg.sv | 32 +++
 rtl/seg_pattern_decoder.sv | 32 +++
 rtl/seg_scan_capture.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the seven-segment scan capture block.
// Holds the active-low segment patterns for digits 0-9 and for a blank digit,
// the capture FSM state type and the default parameter values.
// Segment bit order is {g, f, e, d, c, b, a}, where a 0 bit means the segment is lit.
package seg_scan_pkg;

  localparam int unsigned NumDigitsDef    = 8;
  localparam int unsigned StableCyclesDef = 16;

  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] Seg0     = 7'b1000000;
  localparam logic [6:0] Seg1     = 7'b1111001;
  localparam logic [6:0] Seg2     = 7'b0100100;
  localparam logic [6:0] Seg3     = 7'b0110000;
  localparam logic [6:0] Seg4     = 7'b0011001;
  localparam logic [6:0] Seg5     = 7'b0010010;
  localparam logic [6:0] Seg6     = 7'b0000010;
  localparam logic [6:0] Seg7     = 7'b1111000;
  localparam logic [6:0] Seg8     = 7'b0000000;
  localparam logic [6:0] Seg9     = 7'b0010000;

  // SegDigits[d] is the pattern for digit d.
  localparam logic [9:0][6:0] SegDigits = {Seg9, Seg8, Seg7, Seg6, Seg5,
                                           Seg4, Seg3, Seg2, Seg1, Seg0};

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StHeld
  } state_e;

endpackage

// File: rtl/seg_pattern_decoder.sv
// Combinational decoder that turns an active-low seven-segment pattern into a digit value.
// Ports:
//   seg   - active-low cathodes {g..a}
//   val   - decoded value 0-9; 0 for a blank or unknown pattern
//   blank - the pattern has every segment off
//   err   - the pattern is neither a digit nor blank
module seg_pattern_decoder
  import seg_scan_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] val,
  output logic       blank,
  output logic       err
);

  always_comb begin
    val   = 4'd0;
    blank = 1'b0;
    err   = 1'b1;
    if (seg == SegBlank) begin
      blank = 1'b1;
      err   = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      if (seg == SegDigits[i]) begin
        val = 4'(i);
        err = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Recovers the digit values from a multiplexed, active-low seven-segment display bus.
// A digit is captured once its anode/segment pair has been stable for STABLE_CYCLES
// synchronized cycles.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   an          - active-low anode enables; bit i selects digit i
//   seg         - active-low cathodes {g..a}
//   digit_val   - last captured value for each digit; digit i is at [4i+3:4i]
//   digit_blank - digit i was last captured as blank
//   digit_err   - digit i was last captured as an undecodable pattern
//   upd_valid   - one-cycle strobe for each capture, with upd_idx and upd_val
//   frame_done  - one-cycle strobe when every digit has been captured
module seg_scan_capture
  import seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = NumDigitsDef,
  parameter int unsigned STABLE_CYCLES = StableCyclesDef,
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              seg,
  output logic [4*NUM_DIGITS-1:0] digit_val,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    upd_valid,
  output logic [IdxW-1:0]         upd_idx,
  output logic [3:0]              upd_val,
  output logic                    frame_done
);

  localparam int unsigned SyncW = NUM_DIGITS + 7;
  localparam int unsigned CntW  = $clog2(STABLE_CYCLES);
  // The cycle that detects a change already follows one cycle of the new synchronized
  // value, so the counter only has to cover the remaining STABLE_CYCLES-1 cycles.
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 2);

  // Input synchronizers plus a one-cycle history of the synchronized value.
  logic [SyncW-1:0] r_sync1, r_sync2, r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_prev  <= '1;
    end else begin
      r_sync1 <= {an, seg};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  logic [NUM_DIGITS-1:0] w_an;
  logic [NUM_DIGITS-1:0] w_an_lo;
  logic [6:0]            w_seg;
  logic                  w_change;
  logic                  w_one_hot;
  logic [IdxW-1:0]       w_idx;

  assign w_an      = r_sync2[SyncW-1:7];
  assign w_seg     = r_sync2[6:0];
  assign w_an_lo   = ~w_an;
  assign w_change  = (r_sync2 != r_prev);
  assign w_one_hot = (w_an_lo != '0) && ((w_an_lo & (w_an_lo - 1'b1)) == '0);

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!w_an[i]) w_idx = IdxW'(i);
    end
  end

  logic [3:0] w_dec_val;
  logic       w_dec_blank;
  logic       w_dec_err;

  seg_pattern_decoder u_dec (
    .seg   (w_seg),
    .val   (w_dec_val),
    .blank (w_dec_blank),
    .err   (w_dec_err)
  );

  // Capture FSM: state register, next-state logic, output decode.
  state_e          r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic            w_capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    case (r_state)
      StIdle: begin
        if (w_one_hot) begin
          w_state_d = StSettle;
          w_cnt_d   = '0;
        end
      end
      StSettle: begin
        if (w_change) begin
          w_state_d = w_one_hot ? StSettle : StIdle;
          w_cnt_d   = '0;
        end else if (r_cnt == CntLast) begin
          w_state_d = StHeld;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StHeld: begin
        if (w_change) begin
          w_state_d = w_one_hot ? StSettle : StIdle;
          w_cnt_d   = '0;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    w_capture = (r_state == StSettle) && !w_change && (r_cnt == CntLast);
  end

  // Registered capture results and the per-frame capture mask.
  logic [4*NUM_DIGITS-1:0] r_digit_val;
  logic [NUM_DIGITS-1:0]   r_digit_blank, r_digit_err, r_mask;
  logic                    r_upd_valid, r_frame_done;
  logic [IdxW-1:0]         r_upd_idx;
  logic [3:0]              r_upd_val;
  logic [NUM_DIGITS-1:0]   w_mask_set;

  assign w_mask_set = r_mask | (NUM_DIGITS'(1) << w_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digit_val   <= '0;
      r_digit_blank <= '1;
      r_digit_err   <= '0;
      r_mask        <= '0;
      r_upd_valid   <= 1'b0;
      r_frame_done  <= 1'b0;
      r_upd_idx     <= '0;
      r_upd_val     <= '0;
    end else begin
      r_upd_valid  <= w_capture;
      r_frame_done <= 1'b0;
      if (w_capture) begin
        r_upd_idx                      <= w_idx;
        r_upd_val                      <= w_dec_val;
        r_digit_val[{w_idx, 2'b00} +: 4] <= w_dec_val;
        r_digit_blank[w_idx]           <= w_dec_blank;
        r_digit_err[w_idx]             <= w_dec_err;
        // A recapture of an already-seen digit leaves the mask unchanged.
        if (&w_mask_set) begin
          r_frame_done <= 1'b1;
          r_mask       <= '0;
        end else begin
          r_mask <= w_mask_set;
        end
      end
    end
  end

  assign digit_val   = r_digit_val;
  assign digit_blank = r_digit_blank;
  assign digit_err   = r_digit_err;
  assign upd_valid   = r_upd_valid;
  assign upd_idx     = r_upd_idx;
  assign upd_val     = r_upd_val;
  assign frame_done  = r_frame_done;

endmodule
